if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch controller for the IF stage. Owns the PC register and drives the select of the external 2:1 next-PC mux (in0 = PC+4, in1 = redirect target).
- Sequences instruction-memory requests with a req/ack handshake and buffers returned instructions toward decode, with a one-entry skid buffer.
- Applies stalls from decode and redirects (branch/jump/flush) from EX.

Parameters:
- XLEN, 32: PC and instruction width.
- RESET_PC, 32'h0000_0000: PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_sel  out  1  select to the external next-PC mux; 1 = redirect target.
- pc_plus4  out  XLEN  PC+4, feeds mux in0.
- next_pc_in  in  XLEN  mux output, loaded into PC.
- redirect_valid  in  1  redirect request, single-cycle.
- redirect_pc  in  XLEN  redirect target, feeds mux in1 externally.
- stall  in  1  decode cannot accept this cycle.
- imem_req  out  1  memory request.
- imem_addr  out  XLEN  request address, stable while imem_req=1.
- imem_ack  in  1  data valid, may assert in the same cycle as imem_req.
- imem_rdata  in  XLEN  instruction word.
- if_valid  out  1  if_instr/if_pc valid to decode.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  XLEN  presented instruction.
- misalign_err  out  1  misaligned-redirect pulse (optional feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - pc = RESET_PC, req_addr = RESET_PC, state = IDLE.
  - imem_req = 0, if_valid = 0, if_pc = 0, if_instr = 32'h0000_0013 (NOP).
  - Skid buffer empty, misalign_err = 0.
- Combinational outputs:
  - pc_sel = redirect_valid.
  - pc_plus4 = pc + 4, modulo 2^XLEN (wraps 32'hFFFF_FFFC to 0).
  - imem_addr = req_addr.
- Priority per cycle: redirect > ack > stall.
- Consume rule: when if_valid=1 and stall=0, the output entry is consumed at the edge.
- States:
  - IDLE: imem_req=0. Next cycle → REQ with req_addr = pc.
  - REQ: imem_req=1.
    - ack, no redirect, output free (if_valid=0 or stall=0): if_valid<=1, if_instr<=imem_rdata, if_pc<=req_addr; pc<=next_pc_in (PC+4); req_addr<=next_pc_in; stay in REQ. Sustains 1 instruction/cycle when ack arrives in the same cycle.
    - ack, no redirect, output blocked (if_valid=1 and stall=1): capture into skid; pc advances as above; → HOLD.
    - No ack, no redirect: stay in REQ; hold address.
  - HOLD: imem_req=0. When stall=0: skid → output, skid empties, → REQ.
  - DRAIN: imem_req=1 with the old req_addr until ack. Returned data is discarded; then req_addr<=pc, → REQ.
- Redirect (any state): flushes if_valid and the skid at the edge; pc<=next_pc_in (the target).
  - In REQ with ack in the same cycle: data discarded, req_addr<=target, stay in REQ.
  - In REQ without ack: → DRAIN. The request address is never changed mid-handshake.
  - In DRAIN: pc updated, stay in DRAIN.
  - In HOLD or IDLE: req_addr<=target, → REQ.
- Reset assertion mid-handshake drops imem_req immediately. The memory side must tolerate the abandoned request.
- stall has no effect on imem_req while the output is free.

Optional Feature:
- Macro: IFC_MISALIGN_CHK_EN.
- Defined: a redirect with redirect_pc[1:0] != 0 is rejected.
  - pc_sel is forced to 0 and pc is unchanged.
  - The flush and DRAIN handling still occur.
  - misalign_err pulses 1 cycle, registered, on the edge after the redirect.
- Undefined: no check is made; misalign_err is tied to 0. The port is always present.

Decomposition:
- Shared package if_pkg: fetch state enum (IDLE, REQ, HOLD, DRAIN), NOP constant 32'h0000_0013, default RESET_PC.
- One natural sub-module: if_skid_buf, the 1-entry pc/instr holding register with load/unload/flush.
- The next-PC mux stays external.

Test Plan:
- Reset release, ack tied to req → imem_addr sequence 0x0, 0x4, 0x8. if_valid high from the 2nd edge, if_pc 0x0, 0x4, …, one per cycle.
- Ack delayed 3 cycles → imem_req held and imem_addr stable at 0x4 for 3 cycles. One instruction delivered, no duplicates.
- stall=1 for 4 cycles with an ack pending → skid holds instr@0x8, imem_req=0 in HOLD. After stall drops, decode sees 0x4, 0x8, 0xC in order, none lost.
- redirect_valid with redirect_pc=0x100 while an ack for 0x10 is outstanding → DRAIN discards the 0x10 data. Next request is 0x100; if_valid=0 until instr@0x100.
- PC=0xFFFF_FFFC, fetch with ack → pc_plus4=0x0, next request at 0x0.
- With IFC_MISALIGN_CHK_EN, redirect_pc=0x102 → misalign_err=1 for one cycle. pc is not loaded with 0x102 and the pipeline is flushed.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/if_skid_buf.sv
// One-entry pc/instr holding register that parks a returned word while decode stalls.
// Latency: 1 cycle from load to vld.
// Backpressure: flush wins over load, which wins over unload.
module if_skid_buf
    import if_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            vld,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] instr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld   <= 1'b0;
            pc    <= '0;
            instr <= XLEN'(NOP_INSTR);
        end else if (flush) begin
            vld   <= 1'b0;
        end else if (load) begin
            vld   <= 1'b1;
            pc    <= in_pc;
            instr <= in_instr;
        end else if (unload) begin
            vld   <= 1'b0;
        end
    end
endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: PC register, imem req/ack sequencing, skid-buffered output to decode.
// Latency: instruction presented the edge after ack; 1 instr/cycle with same-cycle ack.
// Backpressure: stall parks one word in the skid and drops imem_req (HOLD). IFC_MISALIGN_CHK_EN rejects misaligned redirects.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            pc_sel,
    output logic [XLEN-1:0] pc_plus4,
    input  logic [XLEN-1:0] next_pc_in,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            misalign_err
);
    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] pc, pc_nx, req_addr, req_addr_nx, redir_tgt;
    logic            redir_ok, redir_bad;
    logic            out_load, skid_load, skid_unload, flush;
    logic            skid_vld;
    logic [XLEN-1:0] skid_pc, skid_instr;

`ifdef IFC_MISALIGN_CHK_EN
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= redir_bad;
    end
`else
    logic unused_redirect_pc;
    assign unused_redirect_pc = ^redirect_pc;
    assign redir_bad    = 1'b0;
    assign misalign_err = 1'b0;
`endif

    assign redir_ok  = redirect_valid && !redir_bad;
    assign pc_sel    = redir_ok;
    assign pc_plus4  = pc + XLEN'(4);
    assign imem_addr = req_addr;
    assign imem_req  = (state == REQ) || (state == DRAIN);
    // A rejected redirect still flushes but refetches from the unchanged pc.
    assign redir_tgt = redir_ok ? next_pc_in : pc;

    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        out_load    = 1'b0;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        flush       = 1'b0;
        if (redirect_valid) begin
            flush = 1'b1;
            pc_nx = redir_tgt;
            case (state)
                REQ: begin
                    if (imem_ack) req_addr_nx = redir_tgt;
                    else          state_nx    = DRAIN;
                end
                DRAIN: begin
                    if (imem_ack) begin
                        req_addr_nx = redir_tgt;
                        state_nx    = REQ;
                    end
                end
                default: begin
                    req_addr_nx = redir_tgt;
                    state_nx    = REQ;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    req_addr_nx = pc;
                    state_nx    = REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        pc_nx       = next_pc_in;
                        req_addr_nx = next_pc_in;
                        if (!if_valid || !stall) begin
                            out_load = 1'b1;
                        end else begin
                            skid_load = 1'b1;
                            state_nx  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        skid_unload = 1'b1;
                        state_nx    = REQ;
                    end
                end
                default: begin
                    if (imem_ack) begin
                        req_addr_nx = pc;
                        state_nx    = REQ;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= XLEN'(NOP_INSTR);
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (out_load) begin
            if_valid <= 1'b1;
            if_pc    <= req_addr;
            if_instr <= imem_rdata;
        end else if (skid_unload) begin
            if_valid <= 1'b1;
            if_pc    <= skid_pc;
            if_instr <= skid_instr;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

    if_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .unload   (skid_unload),
        .flush    (flush),
        .in_pc    (req_addr),
        .in_instr (imem_rdata),
        .vld      (skid_vld),
        .pc       (skid_pc),
        .instr    (skid_instr)
    );

    logic unused_skid_vld;
    assign unused_skid_vld = skid_vld;
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus random traffic against a transaction-level model.
// The model tracks the fetch pc, the outstanding request and an in-order delivery queue.
module tb_if_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_sel;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;
    logic        ack_en;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // External next-PC mux and a memory that answers from its address.
    assign next_pc_in = pc_sel ? redirect_pc : pc_plus4;
    assign imem_ack   = imem_req & ack_en;
    assign imem_rdata = mem_word(imem_addr);

    if_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_sel         (pc_sel),
        .pc_plus4       (pc_plus4),
        .next_pc_in     (next_pc_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_err   (misalign_err)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc, m_addr;
    bit          m_started, m_active, m_discard, m_mis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc      = 32'h0;
        m_addr    = 32'h0;
        m_started = 0;
        m_active  = 0;
        m_discard = 0;
        m_mis     = 0;
    endtask

    function automatic bit is_bad(input logic rv, input logic [31:0] rpc);
`ifdef IFC_MISALIGN_CHK_EN
        return rv && (rpc[1:0] != 2'b00);
`else
        return 1'b0 && rv && rpc[0];
`endif
    endfunction

    task automatic check_outputs(input logic rv, input logic [31:0] rpc);
        chk("imem_req", 32'(imem_req), 32'(m_active));
        if (m_active) chk("imem_addr", imem_addr, m_addr);
        chk("if_valid", 32'(if_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("if_pc", if_pc, q[0].pc);
            chk("if_instr", if_instr, q[0].instr);
        end
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("pc_sel", 32'(pc_sel), 32'(rv && !is_bad(rv, rpc)));
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    task automatic model_update(input logic rv, input logic [31:0] rpc, input logic st, input logic ak);
        bit          ack, bad;
        logic [31:0] tgt;
        ack   = m_active && ak;
        bad   = is_bad(rv, rpc);
        tgt   = bad ? m_pc : rpc;
        m_mis = bad;
        if (rv) begin
            q.delete();
            m_pc = tgt;
            if (m_active && !ack && !m_discard) begin
                m_discard = 1;
            end else if (!(m_discard && !ack)) begin
                m_addr    = tgt;
                m_active  = 1;
                m_discard = 0;
            end
            m_started = 1;
        end else begin
            if (q.size() > 0 && !st) void'(q.pop_front());
            if (!m_started) begin
                m_started = 1;
                m_active  = 1;
                m_addr    = m_pc;
            end else if (ack) begin
                if (m_discard) begin
                    m_discard = 0;
                    m_addr    = m_pc;
                end else begin
                    q.push_back('{pc: m_addr, instr: mem_word(m_addr)});
                    m_pc   = m_pc + 32'd4;
                    m_addr = m_pc;
                    if (q.size() == 2) m_active = 0;
                end
            end else if (!m_active && !st) begin
                m_active = 1;
            end
        end
    endtask

    // Called at a negedge: drive, check settled outputs, advance the model, move to next negedge.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic st, input logic ak);
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall          = st;
        ack_en         = ak;
        #1;
        check_outputs(rv, rpc);
        model_update(rv, rpc, st, ak);
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        ack_en         = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_misalign", 32'(misalign_err), 32'h0);
        model_reset();
        rst_n = 1'b1;

        // Ack tied to req: 0x0, 0x4, 0x8... one per cycle.
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1);
        // Delayed ack: address must hold.
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        // Stall with ack pending: skid fills, request drops.
        repeat (4) step(1'b0, 32'h0, 1'b1, 1'b1);
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1);
        // Redirect while the ack is outstanding: drained word discarded.
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
        // PC wrap at the top of the address space.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef IFC_MISALIGN_CHK_EN
        step(1'b1, 32'h102, 1'b0, 1'b1);
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic        rv;
            logic [31:0] rpc;
            rv  = ($urandom % 8) == 0;
            rpc = $urandom;
`ifndef IFC_MISALIGN_CHK_EN
            rpc[1:0] = 2'b00;
`endif
            if (($urandom % 4) != 0) rpc[1:0] = 2'b00;
            if (($urandom % 16) == 0) rpc = 32'hFFFF_FFF8;
            step(rv, rpc, ($urandom % 3) == 0, ($urandom % 2) == 0);
        end

        // Reset mid-handshake: request must drop without a clock.
        for (int i = 0; i < 20 && !m_active; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_req", 32'(imem_req), 32'(m_active));
        rst_n = 1'b0;
        #1;
        chk("arst_imem_req", 32'(imem_req), 32'h0);
        chk("arst_if_valid", 32'(if_valid), 32'h0);
        chk("arst_imem_addr", imem_addr, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
